// File: rtl/ex_mul.sv
// MIPS32 execute stage: logic/shift/move results, MOVZ/MOVN write gating, HI/LO path.
// MULT/MULTU run on a 32-cycle shift-add unit; define MUL_FAST_EN for a single-cycle multiply.
module ex_mul #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        aluop_i,
   input  logic [2:0]        alusel_i,
   input  logic [DATA_W-1:0] reg1_i,
   input  logic [DATA_W-1:0] reg2_i,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] lo_i,
   input  logic              mem_whilo_i,
   input  logic              wb_whilo_i,
   input  logic [DATA_W-1:0] mem_hi_i,
   input  logic [DATA_W-1:0] mem_lo_i,
   input  logic [DATA_W-1:0] wb_hi_i,
   input  logic [DATA_W-1:0] wb_lo_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              whilo_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              stallreq_o
);

   localparam logic [7:0] OP_AND   = 8'h24;
   localparam logic [7:0] OP_OR    = 8'h25;
   localparam logic [7:0] OP_XOR   = 8'h26;
   localparam logic [7:0] OP_NOR   = 8'h27;
   localparam logic [7:0] OP_SLL   = 8'h7C;
   localparam logic [7:0] OP_SRL   = 8'h02;
   localparam logic [7:0] OP_SRA   = 8'h03;
   localparam logic [7:0] OP_MOVZ  = 8'h0A;
   localparam logic [7:0] OP_MOVN  = 8'h0B;
   localparam logic [7:0] OP_MFHI  = 8'h10;
   localparam logic [7:0] OP_MTHI  = 8'h11;
   localparam logic [7:0] OP_MFLO  = 8'h12;
   localparam logic [7:0] OP_MTLO  = 8'h13;
   localparam logic [7:0] OP_MULT  = 8'h18;
   localparam logic [7:0] OP_MULTU = 8'h19;

   localparam logic [2:0] SEL_LOGIC = 3'd1;
   localparam logic [2:0] SEL_SHIFT = 3'd2;
   localparam logic [2:0] SEL_MOVE  = 3'd3;

   logic [DATA_W-1:0]   hi_f, lo_f;
   logic [DATA_W-1:0]   logic_res, shift_res, move_res;
   logic [CNT_W-1:0]    shamt;
   logic                is_mul, is_mult;
   logic [2*DATA_W-1:0] prod;
   logic                mul_whilo, mul_stall;

   assign shamt   = reg1_i[CNT_W-1:0];
   assign is_mult = (aluop_i == OP_MULT);
   assign is_mul  = is_mult || (aluop_i == OP_MULTU);

   always_comb begin
      hi_f = hi_i;
      lo_f = lo_i;
      if (mem_whilo_i) begin
         hi_f = mem_hi_i;
         lo_f = mem_lo_i;
      end else if (wb_whilo_i) begin
         hi_f = wb_hi_i;
         lo_f = wb_lo_i;
      end
   end

   always_comb begin
      logic_res = '0;
      shift_res = '0;
      move_res  = '0;
      case (aluop_i)
         OP_AND:  logic_res = reg1_i & reg2_i;
         OP_OR:   logic_res = reg1_i | reg2_i;
         OP_XOR:  logic_res = reg1_i ^ reg2_i;
         OP_NOR:  logic_res = ~(reg1_i | reg2_i);
         default: logic_res = '0;
      endcase
      case (aluop_i)
         OP_SLL:  shift_res = reg2_i << shamt;
         OP_SRL:  shift_res = reg2_i >> shamt;
         OP_SRA:  shift_res = $signed(reg2_i) >>> shamt;
         default: shift_res = '0;
      endcase
      case (aluop_i)
         OP_MFHI: move_res = hi_f;
         OP_MFLO: move_res = lo_f;
         OP_MOVZ: move_res = reg1_i;
         OP_MOVN: move_res = reg1_i;
         default: move_res = '0;
      endcase
   end

`ifdef MUL_FAST_EN
   logic [2*DATA_W-1:0] sprod, uprod;
   logic                unused_fast;

   assign sprod = $signed({{DATA_W{reg1_i[DATA_W-1]}}, reg1_i})
                * $signed({{DATA_W{reg2_i[DATA_W-1]}}, reg2_i});
   assign uprod = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};
   assign prod        = is_mult ? sprod : uprod;
   assign mul_whilo   = is_mul && !flush_i;
   assign mul_stall   = 1'b0;
   assign unused_fast = &{1'b0, clk, stall_i};
`else
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [2*DATA_W-1:0] acc_q, mcand_q;
   logic [DATA_W-1:0]   mplier_q;
   logic                neg_q;
   logic [DATA_W-1:0]   abs1, abs2;

   // MULT works on magnitudes; the sign is restored on the final product.
   assign abs1 = (is_mult && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
   assign abs2 = (is_mult && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
   assign prod = neg_q ? -acc_q : acc_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (is_mul && !flush_i) begin
                  mcand_q  <= {{DATA_W{1'b0}}, abs1};
                  mplier_q <= abs2;
                  neg_q    <= is_mult && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                  acc_q    <= '0;
                  cnt_q    <= '0;
               end
            end
            S_BUSY: begin
               if (mplier_q[0])
                  acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      mul_stall = 1'b0;
      mul_whilo = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (is_mul && !flush_i) begin
               state_d   = S_BUSY;
               mul_stall = 1'b1;
            end
         end
         S_BUSY: begin
            mul_stall = 1'b1;
            if (cnt_q == {CNT_W{1'b1}})
               state_d = S_DONE;
         end
         S_DONE: begin
            mul_whilo = 1'b1;
            if (!stall_i)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush_i) begin
         state_d   = S_IDLE;
         mul_stall = 1'b0;
         mul_whilo = 1'b0;
      end
   end
`endif

   always_comb begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
      if (rst) begin
         wd_o   = wd_i;
         wreg_o = wreg_i;
         case (alusel_i)
            SEL_LOGIC: wdata_o = logic_res;
            SEL_SHIFT: wdata_o = shift_res;
            SEL_MOVE:  wdata_o = move_res;
            default:   wdata_o = '0;
         endcase
         if (aluop_i == OP_MOVZ)
            wreg_o = (reg2_i == '0);
         else if (aluop_i == OP_MOVN)
            wreg_o = (reg2_i != '0);
         if (mul_whilo) begin
            whilo_o = 1'b1;
            hi_o    = prod[2*DATA_W-1:DATA_W];
            lo_o    = prod[DATA_W-1:0];
         end else if (aluop_i == OP_MTHI && !flush_i) begin
            whilo_o = 1'b1;
            hi_o    = reg1_i;
            lo_o    = lo_f;
         end else if (aluop_i == OP_MTLO && !flush_i) begin
            whilo_o = 1'b1;
            hi_o    = hi_f;
            lo_o    = reg1_i;
         end
         stallreq_o = mul_stall;
      end
   end

endmodule

// File: tb/tb_ex_mul.sv
// Directed plus randomized checks of ex_mul against a behavioural reference.
module tb_ex_mul;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i, reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] hi_i, lo_i;
   logic        mem_whilo_i, wb_whilo_i;
   logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
   logic        stall_i, flush_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        whilo_o;
   logic [31:0] hi_o, lo_o;
   logic        stallreq_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ex_mul dut (
      .clk(clk), .rst(rst),
      .aluop_i(aluop_i), .alusel_i(alusel_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i),
      .wd_i(wd_i), .wreg_i(wreg_i),
      .hi_i(hi_i), .lo_i(lo_i),
      .mem_whilo_i(mem_whilo_i), .wb_whilo_i(wb_whilo_i),
      .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
      .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
      .stall_i(stall_i), .flush_i(flush_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
      .stallreq_o(stallreq_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] b);
      aluop_i  = op;
      alusel_i = sel;
      reg1_i   = a;
      reg2_i   = b;
   endtask

   function automatic logic [2:0] sel_of(input logic [7:0] op);
      case (op)
         8'h24, 8'h25, 8'h26, 8'h27: return 3'd1;
         8'h7C, 8'h02, 8'h03:        return 3'd2;
         8'h0A, 8'h0B, 8'h10, 8'h12: return 3'd3;
         default:                    return 3'd0;
      endcase
   endfunction

   function automatic void model(
      input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] fh, input logic [31:0] fl, input logic wr,
      output logic [31:0] wd, output logic we, output logic wh,
      output logic [31:0] h, output logic [31:0] l);
      int sh;
      sh = int'(a % 32);
      wd = 0; we = wr; wh = 0; h = 0; l = 0;
      case (op)
         8'h24: wd = a & b;
         8'h25: wd = a | b;
         8'h26: wd = a ^ b;
         8'h27: wd = ~(a | b);
         8'h7C: wd = b << sh;
         8'h02: wd = b >> sh;
         8'h03: wd = 32'($signed(b) >>> sh);
         8'h0A: begin wd = a; we = (b == 0); end
         8'h0B: begin wd = a; we = (b != 0); end
         8'h10: wd = fh;
         8'h12: wd = fl;
         8'h11: begin wh = 1; h = a; l = fl; end
         8'h13: begin wh = 1; h = fh; l = a; end
         default: ;
      endcase
   endfunction

   function automatic logic [63:0] mul_ref(input logic sgn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   task automatic do_mul(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      int n;
      logic [63:0] p;
      p = mul_ref(sgn, a, b);
      step();
      drive(sgn ? 8'h18 : 8'h19, 3'd0, a, b);
      stall_i = 1'b1;
      #1;
      n = 0;
      while (stallreq_o && n < 100) begin
         n++;
         step(); #1;
      end
      chk("mul_stall_cycles", 64'(n), 64'd33);
      chk("mul_whilo", 64'(whilo_o), 64'd1);
      chk("mul_prod", {hi_o, lo_o}, p);
      for (int k = 0; k < hold; k++) begin
         step(); #1;
         chk("done_hold_whilo", 64'(whilo_o), 64'd1);
         chk("done_hold_prod", {hi_o, lo_o}, p);
         chk("done_hold_nostall", 64'(stallreq_o), 64'd0);
      end
      step();
      stall_i = 1'b0;
      #1;
      chk("done_release_whilo", 64'(whilo_o), 64'd1);
      step();
      drive(8'h00, 3'd0, 32'h0, 32'h0);
      #1;
      chk("after_done_idle", {62'b0, whilo_o, stallreq_o}, 64'd0);
   endtask

   task automatic quiet(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < cycles; k++) begin
         step(); #1;
         seen = seen | whilo_o | stallreq_o;
      end
      chk(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [7:0]  ops [13];
      logic [31:0] ewd, eh, el, fh, fl;
      logic        ewe, ewh;

      ops = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03,
              8'h0A, 8'h0B, 8'h10, 8'h11, 8'h12, 8'h13};
      rst = 1'b0;
      drive(8'h25, 3'd1, 32'h1234, 32'h5678);
      wd_i = 5'd3; wreg_i = 1'b1;
      hi_i = 32'h0; lo_i = 32'h0;
      mem_whilo_i = 1'b0; wb_whilo_i = 1'b0;
      mem_hi_i = 0; mem_lo_i = 0; wb_hi_i = 0; wb_lo_i = 0;
      stall_i = 1'b0; flush_i = 1'b0;

      for (int k = 0; k < 2; k++) begin
         step(); #1;
         chk("rst_outs", {wd_o, wreg_o, wdata_o, whilo_o, stallreq_o}, 64'd0);
         chk("rst_hilo", {hi_o, lo_o}, 64'd0);
      end

      step();
      rst = 1'b1;
      drive(8'h25, 3'd1, 32'h1100, 32'h0011);
      #1;
      chk("or_wdata", 64'(wdata_o), 64'h1111);
      chk("or_wd", 64'(wd_o), 64'd3);
      chk("or_wreg", 64'(wreg_o), 64'd1);

      step();
      drive(8'h03, 3'd2, 32'd4, 32'hF000_0000);
      #1;
      chk("sra", 64'(wdata_o), 64'hFF00_0000);

      step();
      drive(8'h0B, 3'd3, 32'hCAFE, 32'd0);
      #1;
      chk("movn_zero_wreg", 64'(wreg_o), 64'd0);
      step();
      drive(8'h0B, 3'd3, 32'hCAFE, 32'd5);
      #1;
      chk("movn_nz_wreg", 64'(wreg_o), 64'd1);
      chk("movn_nz_wdata", 64'(wdata_o), 64'hCAFE);

      step();
      drive(8'h10, 3'd3, 32'h0, 32'h0);
      hi_i = 32'hA; wb_hi_i = 32'hB; wb_whilo_i = 1'b1;
      mem_hi_i = 32'hC; mem_whilo_i = 1'b1;
      #1;
      chk("mfhi_mem", 64'(wdata_o), 64'hC);
      step();
      mem_whilo_i = 1'b0;
      #1;
      chk("mfhi_wb", 64'(wdata_o), 64'hB);
      step();
      wb_whilo_i = 1'b0;
      #1;
      chk("mfhi_arch", 64'(wdata_o), 64'hA);

      for (int i = 0; i < 60; i++) begin
         logic [7:0] op;
         op = ops[$urandom_range(12)];
         step();
         drive(op, sel_of(op), $urandom, ($urandom_range(3) == 0) ? 32'h0 : $urandom);
         hi_i = $urandom; lo_i = $urandom;
         mem_hi_i = $urandom; mem_lo_i = $urandom;
         wb_hi_i = $urandom; wb_lo_i = $urandom;
         mem_whilo_i = 1'($urandom); wb_whilo_i = 1'($urandom);
         wd_i = 5'($urandom); wreg_i = 1'($urandom);
         fh = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
         fl = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);
         model(op, reg1_i, reg2_i, fh, fl, wreg_i, ewd, ewe, ewh, eh, el);
         #1;
         chk("rnd_wdata", 64'(wdata_o), 64'(ewd));
         chk("rnd_wreg_wd", {58'b0, wreg_o, wd_o}, {58'b0, ewe, wd_i});
         chk("rnd_whilo", {62'b0, whilo_o, stallreq_o}, {62'b0, ewh, 1'b0});
         if (ewh)
            chk("rnd_hilo", {hi_o, lo_o}, {eh, el});
      end

      mem_whilo_i = 1'b0; wb_whilo_i = 1'b0;
      step();
      drive(8'h00, 3'd0, 32'h0, 32'h0);

      do_mul(1'b1, 32'hFFFF_FFFE, 32'd3, 0);
      chk("mult_neg_exact", {hi_o, lo_o}, 64'h0);
      do_mul(1'b0, 32'hFFFF_FFFE, 32'd3, 0);
      do_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
      do_mul(1'b1, 32'h0, 32'h1234_5678, 0);
      do_mul(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 3);

      step();
      drive(8'h18, 3'd0, 32'h1234, 32'h5678);
      stall_i = 1'b1;
      #1;
      chk("flush_start_stall", 64'(stallreq_o), 64'd1);
      for (int k = 0; k < 10; k++) step();
      flush_i = 1'b1;
      #1;
      chk("flush_cycle", {62'b0, whilo_o, stallreq_o}, 64'd0);
      step();
      flush_i = 1'b0;
      drive(8'h00, 3'd0, 32'h0, 32'h0);
      #1;
      chk("flush_next_idle", {62'b0, whilo_o, stallreq_o}, 64'd0);
      quiet("flush_no_whilo", 40);
      stall_i = 1'b0;

      for (int i = 0; i < 6; i++)
         do_mul(1'($urandom), $urandom, $urandom, 0);

      step();
      drive(8'h19, 3'd0, 32'hFFFF, 32'hFFFF);
      for (int k = 0; k < 5; k++) step();
      rst = 1'b0;
      drive(8'h00, 3'd0, 32'h0, 32'h0);
      #1;
      chk("rst_busy_outs", {62'b0, whilo_o, stallreq_o}, 64'd0);
      step();
      rst = 1'b1;
      quiet("rst_busy_abort", 40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_mul.md
Name: ex_mul

Overview:
- Execute stage of the 5-stage MIPS32 pipeline. It sits directly downstream of the ID/EX register and consumes the decoded bundle from ID: aluop, alusel, operand 1, operand 2, write-back address and write enable.
- It computes the logic, shift and move results and the final GPR write decision, including the MOVN/MOVZ condition.
- It also runs MULT/MULTU on an iterative 32-cycle shift-add multiplier. The multiplier requests a pipeline stall while busy.
- Outputs feed the EX/MEM register. They also feed back to ID as the EX forwarding path (wreg_o, wd_o, wdata_o).

Parameters:
- DATA_W, 32, operand/GPR width. The product is 2*DATA_W.
- CNT_W, 5, multiplier iteration counter width. Must satisfy 2^CNT_W == DATA_W.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- aluop_i  in  8  ALU op code from ID (defines.h values).
- alusel_i  in  3  result class from ID.
- reg1_i  in  32  operand 1 (forwarded/imm).
- reg2_i  in  32  operand 2 (forwarded/imm).
- wd_i  in  5  destination GPR.
- wreg_i  in  1  GPR write enable from ID.
- hi_i, lo_i  in  32 each  architectural HI/LO from hilo register.
- mem_whilo_i, wb_whilo_i  in  1 each  HI/LO write pending in MEM/WB.
- mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i  in  32 each  pending HI/LO values.
- stall_i  in  1  downstream/global stall holding EX/MEM.
- flush_i  in  1  pipeline flush.
- wd_o  out  5  destination GPR.
- wreg_o  out  1  final GPR write enable.
- wdata_o  out  32  GPR write data.
- whilo_o  out  1  HI/LO write enable.
- hi_o, lo_o  out  32 each  HI/LO write data.
- stallreq_o  out  1  stall request to controller.

Behaviour:
- Op codes:
  - AND=0x24, OR=0x25, XOR=0x26, NOR=0x27
  - SLL=0x7C, SRL=0x02, SRA=0x03
  - MOVZ=0x0A, MOVN=0x0B
  - MFHI=0x10, MTHI=0x11, MFLO=0x12, MTLO=0x13
  - MULT=0x18, MULTU=0x19
- alusel codes: NOP=0, LOGIC=1, SHIFT=2, MOVE=3.
- Logic: bitwise on reg1_i, reg2_i.
- Shift: result = reg2_i shifted by reg1_i[4:0]. SRA is arithmetic. Upper bits of reg1_i are ignored.
- HI/LO source priority:
  - mem_whilo_i set: use mem_hi_i/mem_lo_i.
  - else wb_whilo_i set: use wb_hi_i/wb_lo_i.
  - else: use hi_i/lo_i.
- MFHI/MFLO return the forwarded HI or LO.
- MOVZ/MOVN:
  - wdata_o = reg1_i.
  - MOVZ: wreg_o = (reg2_i==0).
  - MOVN: wreg_o = (reg2_i!=0).
  - This overrides wreg_i.
- MTHI: whilo_o=1, hi_o=reg1_i, lo_o=forwarded LO.
- MTLO: whilo_o=1, lo_o=reg1_i, hi_o=forwarded HI.
- Other ops: wreg_o = wreg_i. wdata_o selects by alusel_i; NOP and unknown classes give 0. wd_o = wd_i combinationally.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE, aluop_i is MULT/MULTU, flush_i=0:
    - Latch operands: absolute values for MULT, raw values for MULTU.
    - Latch neg = reg1_i[31]^reg2_i[31] for MULT, 0 for MULTU.
    - Clear accumulator and counter, go to BUSY.
  - BUSY: each cycle, if multiplier bit0 is set, add the multiplicand to the accumulator. Shift multiplicand left 1 and multiplier right 1. Increment counter. When counter==31, go to DONE.
  - DONE: product = neg ? two's-complement(acc) : acc, 64 bits. Drive whilo_o=1, hi_o=product[63:32], lo_o=product[31:0].
    - stall_i=1: stay in DONE.
    - else: go to IDLE.
- stallreq_o = (IDLE & op is MULT/MULTU & !flush_i) | BUSY.
  - Cycle 0 is the op presented; cycles 1..32 are BUSY; cycle 33 is DONE.
  - stallreq_o is high for 33 cycles. Result is valid in cycle 33.
- flush_i=1 in any state: next state IDLE. In that cycle whilo_o=0 and stallreq_o=0.
- Reset (rst==0 at clk edge): state IDLE, counter 0, accumulator and operand latches 0.
- While rst==0, all outputs are forced to 0 combinationally.
- Reset mid-BUSY aborts the multiply with no HI/LO write.
- Edge cases:
  - MULT 0x80000000*0x80000000: abs operand 0x80000000 (unsigned), product 0x4000000000000000.
  - Operand 0: the full 33-cycle stall still applies.

Optional Feature:
- Macro MUL_FAST_EN.
- Defined:
  - FSM and counter are removed.
  - MULT/MULTU compute the 64-bit product combinationally with native signed/unsigned multiply in cycle 0.
  - whilo_o=1 in that cycle; stallreq_o is tied 0.
- Undefined: the iterative FSM above is used.

Test Plan:
- rst=0 for 2 cycles with aluop_i=0x25 and reg1_i/reg2_i nonzero -> all outputs 0, stallreq_o=0. Then rst=1 -> OR result valid in the same cycle.
- OR 0x1100|0x0011, wd_i=3, wreg_i=1 -> wdata_o=0x1111, wd_o=3, wreg_o=1. SRA with reg1_i=4, reg2_i=0xF0000000 -> 0xFF000000.
- MOVN with reg2_i=0 -> wreg_o=0. MOVN with reg2_i=5 -> wreg_o=1, wdata_o=reg1_i.
- MFHI with hi_i=0xA, wb_hi_i=0xB (wb_whilo_i=1), mem_hi_i=0xC (mem_whilo_i=1) -> wdata_o=0xC. Drop mem_whilo_i -> 0xB.
- MULT 0xFFFFFFFE*3 held under stall -> stallreq_o high for exactly 33 cycles. Cycle 33: whilo_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA. MULTU of the same operands -> hi_o=0x2, lo_o=0xFFFFFFFA.
- MULT started, flush_i=1 at BUSY cycle 10 -> next cycle IDLE, stallreq_o=0, no whilo_o pulse. stall_i=1 during DONE for 3 cycles -> whilo_o stays 1 with the product stable, and no restart occurs.
